i2c_mst_ctrl_byte: RTL

Byte-level command sequencer for the I2C master, sitting directly upstream of `i2c_phy`. It accepts byte commands (start, stop, read, write, with ACK control) from the register/host layer and breaks each into the 4-bit bit-level command sequence consumed by the phy's `cmd`/`din` port. It consumes the phy's `cmd_ack`, `al` and `dout` handshakes, shifts 8 data bits MSB-first, and collects or drives the acknowledge bit. It reports byte completion, ACK status and arbitration loss upward.

---
 rtl/i2c_mst_ctrl_byte_if.sv | 32 +++
 rtl/i2c_mst_ctrl_byte.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/i2c_mst_ctrl_byte_if.sv
// Host- and phy-facing signal bundle for the I2C byte command sequencer.
// The master modport is the sequencer itself; slave is the host/phy side.
interface i2c_mst_ctrl_byte_if;
  logic       ena;
  logic       start;
  logic       stop;
  logic       read;
  logic       write;
  logic       ack_in;
  logic [7:0] din;
  logic       cmd_ack;
  logic       ack_out;
  logic [7:0] dout;
  logic       i2c_al;
  logic [3:0] bit_cmd;
  logic       bit_din;
  logic       bit_ack;
  logic       bit_al;
  logic       bit_dout;

  modport master (
    input  ena, start, stop, read, write, ack_in, din,
    input  bit_ack, bit_al, bit_dout,
    output cmd_ack, ack_out, dout, i2c_al, bit_cmd, bit_din
  );

  modport slave (
    output ena, start, stop, read, write, ack_in, din,
    output bit_ack, bit_al, bit_dout,
    input  cmd_ack, ack_out, dout, i2c_al, bit_cmd, bit_din
  );
endinterface

// File: rtl/i2c_mst_ctrl_byte.sv
// Byte-level I2C command sequencer: splits start/write/read/stop byte commands into
// single-bit phy commands, shifting data MSB-first and handling the ACK slot.
module i2c_mst_ctrl_byte (
  input  logic                  clk,
  input  logic                  rstn,
  i2c_mst_ctrl_byte_if.master   bus
);

  typedef enum logic [2:0] {StIdle, StStart, StWrite, StRead, StAck, StStop} state_e;

  localparam logic [3:0] CmdNop   = 4'b0000;
  localparam logic [3:0] CmdStart = 4'b0001;
  localparam logic [3:0] CmdStop  = 4'b0010;
  localparam logic [3:0] CmdWrite = 4'b0100;
  localparam logic [3:0] CmdRead  = 4'b1000;

  state_e     state_q, state_d;
  logic [7:0] sr_q, sr_d;
  logic [2:0] cnt_q, cnt_d;
  logic [3:0] bit_cmd_q, bit_cmd_d;
  logic       bit_din_q, bit_din_d;
  logic       cmd_ack_q, cmd_ack_d;
  logic       ack_out_q, ack_out_d;
  logic       i2c_al_q, i2c_al_d;
  logic       go;

  // The registered cmd_ack blocks a re-trigger while the host is dropping its request.
  assign go = (bus.read | bus.write | bus.stop) & ~cmd_ack_q & bus.ena;

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    bit_cmd_d = bit_cmd_q;
    bit_din_d = bit_din_q;
    ack_out_d = ack_out_q;
    cmd_ack_d = 1'b0;
    i2c_al_d  = 1'b0;

    if (bus.bit_al) begin
      state_d   = StIdle;
      bit_cmd_d = CmdNop;
      i2c_al_d  = 1'b1;
    end else if (!bus.ena) begin
      state_d   = StIdle;
      bit_cmd_d = CmdNop;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (go) begin
            sr_d  = bus.din;
            cnt_d = 3'd7;
            if (bus.start) begin
              state_d   = StStart;
              bit_cmd_d = CmdStart;
            end else if (bus.read) begin
              state_d   = StRead;
              bit_cmd_d = CmdRead;
            end else if (bus.write) begin
              state_d   = StWrite;
              bit_cmd_d = CmdWrite;
              bit_din_d = bus.din[7];
            end else begin
              state_d   = StStop;
              bit_cmd_d = CmdStop;
            end
          end
        end

        StStart: begin
          if (bus.bit_ack) begin
            if (bus.read) begin
              state_d   = StRead;
              bit_cmd_d = CmdRead;
            end else begin
              state_d   = StWrite;
              bit_cmd_d = CmdWrite;
              bit_din_d = sr_q[7];
            end
          end
        end

        StWrite, StRead: begin
          if (bus.bit_ack) begin
            sr_d = {sr_q[6:0], bus.bit_dout};
            if (cnt_q != 3'd0) begin
              cnt_d = cnt_q - 3'd1;
              // sr_q[6] becomes the MSB after this shift.
              if (state_q == StWrite) bit_din_d = sr_q[6];
            end else begin
              state_d = StAck;
              if (state_q == StWrite) begin
                bit_cmd_d = CmdRead;
              end else begin
                bit_cmd_d = CmdWrite;
                bit_din_d = bus.ack_in;
              end
            end
          end
        end

        StAck: begin
          if (bus.bit_ack) begin
            ack_out_d = bus.bit_dout;
            if (bus.stop) begin
              state_d   = StStop;
              bit_cmd_d = CmdStop;
            end else begin
              state_d   = StIdle;
              bit_cmd_d = CmdNop;
              cmd_ack_d = 1'b1;
            end
          end
        end

        StStop: begin
          if (bus.bit_ack) begin
            state_d   = StIdle;
            bit_cmd_d = CmdNop;
            cmd_ack_d = 1'b1;
          end
        end

        default: begin
          state_d   = StIdle;
          bit_cmd_d = CmdNop;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StIdle;
      sr_q      <= 8'h00;
      cnt_q     <= 3'd0;
      bit_cmd_q <= CmdNop;
      bit_din_q <= 1'b0;
      cmd_ack_q <= 1'b0;
      ack_out_q <= 1'b0;
      i2c_al_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      bit_cmd_q <= bit_cmd_d;
      bit_din_q <= bit_din_d;
      cmd_ack_q <= cmd_ack_d;
      ack_out_q <= ack_out_d;
      i2c_al_q  <= i2c_al_d;
    end
  end

  assign bus.cmd_ack = cmd_ack_q;
  assign bus.ack_out = ack_out_q;
  assign bus.dout    = sr_q;
  assign bus.i2c_al  = i2c_al_q;
  assign bus.bit_cmd = bit_cmd_q;
  assign bus.bit_din = bit_din_q;

endmodule
